// File: rtl/scratchpad_sram_arbiter.sv
// Round-robin arbiter sharing the scratchpad SRAM write/read ports among NUM_REQ requesters.
// Optional: define SCRATCHPAD_ARB_STATS_EN to add a saturating stall_count output.
module scratchpad_sram_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      scratchpad_sram_write_enable,
  output logic [ADDR_W-1:0]         scratchpad_sram_write_addresss,
  output logic [DATA_W-1:0]         scratchpad_sram_write_data,
  output logic [ADDR_W-1:0]         scratchpad_sram_read_address,
  input  logic [DATA_W-1:0]         scratchpad_sram_read_data
`ifdef SCRATCHPAD_ARB_STATS_EN
  ,
  output logic [15:0]               stall_count
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [CW-1:0]    cand;

  // Rotating priority: candidates rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first valid wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!gnt_any && req_valid[cand[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Grant is forced low while reset is held so no request is consumed during reset.
  always_comb begin
    req_grant = '0;
    if (gnt_any && reset_b) req_grant[gnt_idx] = 1'b1;
  end

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              wr_go, rd_go;

  assign sel_write = req_write[gnt_idx];
  assign sel_addr  = addr_a[gnt_idx];
  assign sel_wdata = wdata_a[gnt_idx];
  assign wr_go     = gnt_any & sel_write;
  assign rd_go     = gnt_any & ~sel_write;
  assign rr_ptr_d  = gnt_any ? ((gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1)) : rr_ptr_q;

  logic              we_q;
  logic [ADDR_W-1:0] waddr_q, raddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:1]             vld_pipe_q;
  logic [2:1][PTR_W-1:0]  tag_pipe_q;

  // Read tag rides alongside the SRAM access: stage 1 = address presented, stage 2 = data back.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rr_ptr_q   <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      raddr_q    <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= wr_go;
      if (wr_go) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (rd_go) raddr_q <= sel_addr;
      vld_pipe_q    <= {vld_pipe_q[1], rd_go};
      tag_pipe_q[1] <= gnt_idx;
      tag_pipe_q[2] <= tag_pipe_q[1];
    end
  end

  assign scratchpad_sram_write_enable   = we_q;
  assign scratchpad_sram_write_addresss = waddr_q;
  assign scratchpad_sram_write_data     = wdata_q;
  assign scratchpad_sram_read_address   = raddr_q;

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (vld_pipe_q[2]) begin
      rsp_valid[tag_pipe_q[2]] = 1'b1;
      rsp_data                 = scratchpad_sram_read_data;
    end
  end

`ifdef SCRATCHPAD_ARB_STATS_EN
  logic [15:0] stall_cnt_q;
  logic        stall_c;

  assign stall_c = |(req_valid & ~req_grant);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                                stall_cnt_q <= '0;
    else if (stall_c && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule
